// File: rtl/nitta_spi_tx_arbiter_if.sv
// Bundle between the NITTA requesters / SPI master and the transmit arbiter.
// The arbiter takes the slave view; stimulus or surrounding logic takes the master view.
interface nitta_spi_tx_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int N_REQ          = 2
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] data_in;
    logic [N_REQ-1:0]            grant;
    logic [N_REQ-1:0]            ack;
    logic [SPI_DATA_WIDTH-1:0]   to_spi;
    logic                        spi_valid;
    logic                        spi_ready;
    logic                        busy;

    modport master (
        output req, data_in, spi_ready,
        input  grant, ack, to_spi, spi_valid, busy
    );

    modport slave (
        input  req, data_in, spi_ready,
        output grant, ack, to_spi, spi_valid, busy
    );
endinterface

// File: rtl/nitta_spi_tx_arbiter.sv
// Round-robin arbiter feeding one SPI transmit lane: latches the granted word
// and streams it MSB chunk first, one chunk per spi_ready strobe, then acks.
module nitta_spi_tx_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int N_REQ          = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    nitta_spi_tx_arbiter_if.slave bus
);
    localparam int CHUNKS = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

    generate
        if ((DATA_WIDTH % SPI_DATA_WIDTH) != 0 || CHUNKS < 1 || N_REQ < 1 || N_REQ > 8) begin : g_bad_params
            $error("nitta_spi_tx_arbiter: illegal DATA_WIDTH/SPI_DATA_WIDTH/N_REQ combination");
        end
    endgenerate

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_reg;
    logic [N_REQ-1:0]      grant_reg;
    logic [N_REQ-1:0]      ack_reg;
    logic [N_REQ-1:0]      last_oh_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         cnt_reg;
    logic                  valid_reg;

    // Requesters strictly above the last winner get first pick; if none of
    // them is asking, wrap around and take the lowest requesting index.
    logic [N_REQ-1:0] above_mask;
    logic [N_REQ-1:0] masked_req;
    logic [N_REQ-1:0] win_oh;

    assign above_mask = ~((last_oh_reg << 1) - N_REQ'(1));
    assign masked_req = bus.req & above_mask;
    assign win_oh     = (|masked_req) ? (masked_req & (~masked_req + N_REQ'(1)))
                                      : (bus.req & (~bus.req + N_REQ'(1)));

    logic [DATA_WIDTH-1:0] sel_word [N_REQ];
    logic [DATA_WIDTH-1:0] win_word;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sel
            assign sel_word[gi] = {DATA_WIDTH{win_oh[gi]}} & bus.data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        win_word = '0;
        for (int k = 0; k < N_REQ; k++) begin
            win_word = win_word | sel_word[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            ack_reg     <= '0;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            valid_reg   <= 1'b0;
            last_oh_reg <= N_REQ'(1) << (N_REQ - 1);
        end else begin
            ack_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (|bus.req) begin
                        grant_reg <= win_oh;
                        shift_reg <= win_word;
                        cnt_reg   <= '0;
                        valid_reg <= 1'b1;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (bus.spi_ready) begin
                        if (cnt_reg == LAST_CHUNK) begin
                            ack_reg     <= grant_reg;
                            last_oh_reg <= grant_reg;
                            grant_reg   <= '0;
                            shift_reg   <= '0;
                            valid_reg   <= 1'b0;
                            state_reg   <= IDLE;
                        end else begin
                            shift_reg <= shift_reg << SPI_DATA_WIDTH;
                            cnt_reg   <= cnt_reg + CW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_reg;
    assign bus.ack       = ack_reg;
    assign bus.to_spi    = shift_reg[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
    assign bus.spi_valid = valid_reg;
    assign bus.busy      = valid_reg;
endmodule

// File: doc/nitta_spi_tx_arbiter.md
Name: nitta_spi_tx_arbiter

Overview:
- Shares one SPI transmit byte lane between N_REQ NITTA-side requesters, each offering a DATA_WIDTH word.
- Grants requesters round-robin, latches the granted word and sends it MSB-chunk-first as SPI_DATA_WIDTH chunks. Advances one chunk per spi_ready strobe from the SPI master.
- Returns a one-cycle ack to the requester once its last chunk is consumed.
- Sits between the processor-unit output buffers and the SPI master.

Parameters:
DATA_WIDTH, 32, width of one requester word
SPI_DATA_WIDTH, 8, width of one SPI chunk; DATA_WIDTH must be an integer multiple (CHUNKS = DATA_WIDTH/SPI_DATA_WIDTH >= 1); otherwise illegal
N_REQ, 2, number of requesters (1..8)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low
req  in  N_REQ  per-requester transfer request, held until ack
data_in  in  N_REQ*DATA_WIDTH  packed words, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
grant  out  N_REQ  one-hot, requester currently being served
ack  out  N_REQ  one-cycle pulse, requester's word fully consumed
to_spi  out  SPI_DATA_WIDTH  current chunk toward SPI master
spi_valid  out  1  to_spi holds a valid chunk
spi_ready  in  1  SPI master consumed the current chunk (sampled only when spi_valid=1)
busy  out  1  transfer in progress (equals spi_valid)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; grant=0, ack=0, to_spi=0, spi_valid=0, busy=0; chunk counter=0; round-robin pointer set so requester 0 has highest priority.
- States: IDLE, SEND.
- IDLE, posedge with any req bit set:
  - Winner = first set req bit searching upward from (last_granted+1) mod N_REQ.
  - Latch data_in of winner into shift register; grant=onehot(winner); counter=0; spi_valid=1; to_spi=top chunk of word; go SEND.
  - Latency: req sampled at edge k -> to_spi/spi_valid valid after edge k.
- IDLE with req=0: stay; spi_ready ignored.
- SEND, posedge with spi_ready=1:
  - counter<CHUNKS-1: shift word left by SPI_DATA_WIDTH; to_spi=next chunk; counter+1.
  - counter==CHUNKS-1: ack[winner]=1 for exactly this next cycle; grant=0; spi_valid=0; to_spi=0; last_granted=winner; go IDLE.
- SEND, posedge with spi_ready=0: hold to_spi, counter, grant unchanged.
- spi_ready held high: one chunk per cycle, so a word occupies CHUNKS cycles in SEND.
- Minimum one IDLE cycle between words; next grant at earliest the edge after ack is asserted.
- Requester must drop or re-arm req on the cycle ack is seen. A req still high in the IDLE cycle after ack counts as a new request; the requester is then re-granted only if no other requester is pending.
- req deassert or data_in change during SEND ignored; the latched word completes.
- CHUNKS=1: ack on the first spi_ready strobe.
- rst asserted mid-transfer: transfer aborted, no ack issued, outputs to reset values immediately.
- Invariants: grant at most one bit set; ack at most one bit set; ack and grant never both set for the same requester.

Test Plan:
- N_REQ=2; req=01, data0=A0B1C2D3; spi_ready pattern 0,1,0,1,0,0,0,1,0,1 -> to_spi A0,B1,B1,C2,C2,C2,C2,D3,D3. ack=01 pulses one cycle after the final strobe; then spi_valid=0, to_spi=00.
- req=11 simultaneously, data0=11223344, data1=55667788, spi_ready always 1:
  - Grant order 01 then 10.
  - to_spi sequence 11,22,33,44, then one idle cycle, then 55,66,77,88.
  - ack=01 then ack=10.
- Fairness: both req held continuously for 4 words -> grants alternate 01,10,01,10; no requester is served twice in a row.
- Reset mid-word: grant requester 0, after chunk B1 drive rst=0 -> grant=0, spi_valid=0, to_spi=0, no ack. Release reset with req=10 -> requester 1 is granted and sends its word from its top chunk.
- Ignored inputs:
  - spi_ready=1 pulses while IDLE and req=0 -> no state change, outputs stay 0.
  - data_in changed during SEND -> transmitted chunks still match the word latched at grant.
- Parameter variant SPI_DATA_WIDTH=32, data0=DEADBEEF -> single chunk DEADBEEF; ack on the first spi_ready strobe.
